row_config_loader: RTL and testbench

ROW_CONFIG_LOADER -- requirements
Module: row_config_loader

---
 rtl/row_cfg_pkg.sv | 16 +
 rtl/cfg_shift_accum.sv | 35 +++
 rtl/row_config_loader.sv | 135 +++++++++++++
 tb/tb_row_config_loader.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/row_cfg_pkg.sv
// rtl/row_cfg_pkg.sv - shared widths and loader state encoding for the routing-row config loader
package row_cfg_pkg;

  localparam int BRB_BITS = 36;
  localparam int NBRB     = 5;
  localparam int NBITS    = BRB_BITS * NBRB;
  localparam int CHK_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/cfg_shift_accum.sv
// rtl/cfg_shift_accum.sv - shadow shift register with running ones count for the payload bits
module cfg_shift_accum #(
  parameter int NBITS = 180,
  parameter int CHK_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             shift_i,
  input  logic             bit_i,
  output logic [NBITS-1:0] shadow_o,
  output logic [CHK_W-1:0] ones_o
);

  logic [NBITS-1:0] shadow_q;
  logic [CHK_W-1:0] ones_q;

  // Bits enter at the MSB so the first bit received finishes at bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_q <= '0;
      ones_q   <= '0;
    end else if (clear_i) begin
      shadow_q <= '0;
      ones_q   <= '0;
    end else if (shift_i) begin
      shadow_q <= {bit_i, shadow_q[NBITS-1:1]};
      ones_q   <= ones_q + CHK_W'(bit_i);
    end
  end

  assign shadow_o = shadow_q;
  assign ones_o   = ones_q;

endmodule

// File: rtl/row_config_loader.sv
// rtl/row_config_loader.sv - serial loader that checksums a row config frame and commits it to brbselect
module row_config_loader #(
  parameter int NBITS = row_cfg_pkg::NBITS,
  parameter int CHK_W = row_cfg_pkg::CHK_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             cfg_data,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [NBITS-1:0] brbselect,
  output logic             busy,
  output logic             cfg_done,
  output logic             cfg_err
);

  import row_cfg_pkg::*;

  localparam int CW = $clog2((NBITS > CHK_W) ? NBITS : CHK_W);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CHK_W-1:0] check_q, check_d;
  logic [NBITS-1:0] brb_q, brb_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             accept;
  logic             acc_clear;
  logic             acc_shift;
  logic [NBITS-1:0] shadow;
  logic [CHK_W-1:0] ones;

  cfg_shift_accum #(
    .NBITS(NBITS),
    .CHK_W(CHK_W)
  ) u_accum (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (acc_clear),
    .shift_i (acc_shift),
    .bit_i   (cfg_data),
    .shadow_o(shadow),
    .ones_o  (ones)
  );

  assign cfg_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  // Abort outranks a bit offered on the same edge.
  assign accept    = cfg_valid && cfg_ready && !cfg_abort;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    check_d   = check_q;
    brb_d     = brb_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    acc_clear = 1'b0;
    acc_shift = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          check_d   = '0;
          acc_clear = 1'b1;
        end
      end
      ST_LOAD: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          acc_shift = 1'b1;
          if (cnt_q == CW'(NBITS - 1)) begin
            state_d = ST_CHECK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (cfg_abort) begin
          state_d = ST_IDLE;
        end else if (accept) begin
          check_d = {check_q[CHK_W-2:0], cfg_data};
          if (cnt_q == CW'(CHK_W - 1)) begin
            state_d = ST_COMMIT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (!cfg_abort) begin
          if (check_q == ones) begin
            brb_d  = shadow;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      check_q <= '0;
      brb_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      check_q <= check_d;
      brb_q   <= brb_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign brbselect = brb_q;
  assign busy      = (state_q != ST_IDLE);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_row_config_loader.sv
// tb/tb_row_config_loader.sv - directed self-checking bench for row_config_loader
module tb_row_config_loader;

  localparam int NB = 180;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_start;
  logic          cfg_abort;
  logic          cfg_data;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [NB-1:0] brbselect;
  logic          busy;
  logic          cfg_done;
  logic          cfg_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB-1:0] all_ones;
  logic [NB-1:0] zeros;
  logic [NB-1:0] sparse;
  logic [NB-1:0] pat;

  row_config_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_data (cfg_data),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .brbselect(brbselect),
    .busy     (busy),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    cfg_valid = 1'b1;
    cfg_data  = b;
    @(negedge clk);
    cfg_valid = 1'b0;
    if (gap) begin
      cfg_data = ~b;
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input string tag);
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk1({tag, "_busy_load"}, busy, 1'b1);
    chk1({tag, "_ready_load"}, cfg_ready, 1'b1);
  endtask

  task automatic send_frame(input logic [NB-1:0] pl, input logic [7:0] ck, input bit gaps,
                            input bit exp_ok, input logic [NB-1:0] exp_brb, input string tag);
    start_frame(tag);
    for (int i = 0; i < NB; i++) send_bit(pl[i], gaps);
    chk1({tag, "_ready_check"}, cfg_ready, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(ck[7-i], gaps && (i != 7));
    chk1({tag, "_commit_ready"}, cfg_ready, 1'b0);
    chk1({tag, "_commit_busy"}, busy, 1'b1);
    chk1({tag, "_commit_done"}, cfg_done, 1'b0);
    @(negedge clk);
    chk1({tag, "_done"}, cfg_done, exp_ok);
    chk1({tag, "_err"}, cfg_err, !exp_ok);
    chkv({tag, "_brb"}, brbselect, exp_brb);
    chk1({tag, "_idle"}, busy, 1'b0);
    @(negedge clk);
    chk1({tag, "_done_clr"}, cfg_done, 1'b0);
    chk1({tag, "_err_clr"}, cfg_err, 1'b0);
    chkv({tag, "_brb_hold"}, brbselect, exp_brb);
  endtask

  initial begin
    all_ones  = '1;
    zeros     = '0;
    sparse    = '0;
    sparse[0] = 1'b1;
    sparse[37] = 1'b1;
    pat       = '0;
    pat[15:0] = 16'hF0F0;

    rst_n = 1'b0; cfg_start = 1'b0; cfg_abort = 1'b0; cfg_data = 1'b0; cfg_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chkv("rst_brb", brbselect, zeros);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_ready", cfg_ready, 1'b0);
    chk1("rst_done", cfg_done, 1'b0);
    chk1("rst_err", cfg_err, 1'b0);
    rst_n = 1'b1;

    // start together with abort in IDLE does nothing
    cfg_start = 1'b1; cfg_abort = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_abort = 1'b0;
    chk1("start_abort_idle", busy, 1'b0);

    send_frame(zeros, 8'h00, 1'b0, 1'b1, zeros, "zeros");
    send_frame(all_ones, 8'hB5, 1'b0, 1'b0, zeros, "ones_bad");
    send_frame(all_ones, 8'hB4, 1'b0, 1'b1, all_ones, "ones_ok");

    // abort after 90 bits; a start mid-load must not restart the frame
    start_frame("abort");
    for (int i = 0; i < 45; i++) send_bit(1'b1, 1'b0);
    cfg_start = 1'b1;
    send_bit(1'b0, 1'b0);
    cfg_start = 1'b0;
    chk1("abort_start_ignored_busy", busy, 1'b1);
    for (int i = 0; i < 44; i++) send_bit(1'b0, 1'b0);
    cfg_abort = 1'b1;
    send_bit(1'b1, 1'b0);
    cfg_abort = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", cfg_ready, 1'b0);
    chk1("abort_done", cfg_done, 1'b0);
    chk1("abort_err", cfg_err, 1'b0);
    @(negedge clk);
    chk1("abort_done2", cfg_done, 1'b0);
    chk1("abort_err2", cfg_err, 1'b0);
    chkv("abort_brb", brbselect, all_ones);

    // reset mid-frame after 120 bits
    start_frame("rstmid");
    for (int i = 0; i < 120; i++) send_bit(1'b1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chkv("rstmid_brb", brbselect, zeros);
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_ready", cfg_ready, 1'b0);
    send_bit(1'b1, 1'b0);
    chk1("rstmid_no_restart", busy, 1'b0);
    chk1("rstmid_ready2", cfg_ready, 1'b0);

    send_frame(sparse, 8'h02, 1'b1, 1'b1, sparse, "sparse_gap");
    send_frame(pat, 8'h08, 1'b0, 1'b1, pat, "pat");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
